gmii_rx_parser: RTL

//  Consumes GMII receive traffic (rxd/rx_dv) and removes preamble/SFD.

---
 rtl/gmii_rx_parser.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/gmii_rx_parser.sv
// GMII receive parser: strips preamble/SFD and FCS, checks CRC-32, and
// queues frame bytes with SOP/MOP/EOP codes into an output FIFO.
module gmii_rx_parser #(
  parameter int FIFO_DEPTH = 16,
  parameter bit PREAMBLE   = 1'b1
) (
  input  logic       rx_clk,
  input  logic       reset_n,
  input  logic [7:0] rxd,
  input  logic       rx_dv,
  output logic       p_srdy,
  input  logic       p_drdy,
  output logic [7:0] p_data,
  output logic [1:0] p_code,
  output logic       stat_good,
  output logic       stat_crc_err,
  output logic       stat_ovf,
  output logic       stat_runt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ROOM_MAX = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  localparam logic [1:0] C_MOP  = 2'b00;
  localparam logic [1:0] C_SOP  = 2'b01;
  localparam logic [1:0] C_EOPG = 2'b10;
  localparam logic [1:0] C_EOPB = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [4:0][7:0] dly_q, dly_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            sop_q, sop_d;
  logic [AW:0]     wptr_q, rptr_q, used;
  logic            wr_en, rd_en, crc_ok;
  logic [9:0]      wr_ent;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic            good_d, crc_err_d, ovf_d, runt_d;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  assign used   = wptr_q - rptr_q;
  assign p_srdy = (used != '0);
  assign rd_en  = p_srdy & p_drdy;
  assign crc_ok = (crc_q == RESIDUE);
  assign {p_code, p_data} = p_srdy ? mem_q[rptr_q[AW-1:0]] : 10'h000;

  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    sop_d     = sop_q;
    wr_en     = 1'b0;
    wr_ent    = {C_MOP, dly_q[4]};
    good_d    = 1'b0;
    crc_err_d = 1'b0;
    ovf_d     = 1'b0;
    runt_d    = 1'b0;
    case (state_q)
      S_IDLE: if (rx_dv) begin
        crc_d = '1;
        cnt_d = '0;
        sop_d = 1'b0;
        if (!PREAMBLE) begin
          crc_d   = crc_byte('1, rxd);
          dly_d   = {dly_q[3:0], rxd};
          cnt_d   = 3'd1;
          state_d = S_DATA;
        end else if (rxd == 8'h55) begin
          state_d = S_PRE;
        end else begin
          runt_d  = 1'b1;
          state_d = S_DROP;
        end
      end
      S_PRE: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end else if (rxd == 8'hD5) begin
          crc_d   = '1;
          cnt_d   = '0;
          sop_d   = 1'b0;
          state_d = S_DATA;
        end else if (rxd != 8'h55) begin
          runt_d  = 1'b1;
          state_d = S_DROP;
        end
      end
      S_DATA: begin
        if (rx_dv) begin
          crc_d = crc_byte(crc_q, rxd);
          if (cnt_q != 3'd5) begin
            dly_d = {dly_q[3:0], rxd};
            cnt_d = cnt_q + 3'd1;
          end else if (used <= ROOM_MAX) begin
            wr_en  = 1'b1;
            wr_ent = {sop_q ? C_MOP : C_SOP, dly_q[4]};
            sop_d  = 1'b1;
            dly_d  = {dly_q[3:0], rxd};
          end else begin
            // last free slot is kept for this terminator
            wr_en   = sop_q;
            wr_ent  = {C_EOPB, dly_q[4]};
            ovf_d   = 1'b1;
            state_d = S_DROP;
          end
        end else begin
          state_d = S_IDLE;
          if (sop_q) begin
            wr_en     = 1'b1;
            wr_ent    = {crc_ok ? C_EOPG : C_EOPB, dly_q[4]};
            good_d    = crc_ok;
            crc_err_d = !crc_ok;
          end else begin
            runt_d = 1'b1;
          end
        end
      end
      S_DROP: if (!rx_dv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      crc_q        <= '1;
      dly_q        <= '0;
      cnt_q        <= '0;
      sop_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      stat_good    <= 1'b0;
      stat_crc_err <= 1'b0;
      stat_ovf     <= 1'b0;
      stat_runt    <= 1'b0;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      dly_q        <= dly_d;
      cnt_q        <= cnt_d;
      sop_q        <= sop_d;
      wptr_q       <= wptr_q + (AW+1)'(wr_en);
      rptr_q       <= rptr_q + (AW+1)'(rd_en);
      stat_good    <= good_d;
      stat_crc_err <= crc_err_d;
      stat_ovf     <= ovf_d;
      stat_runt    <= runt_d;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (wr_en) mem_q[wptr_q[AW-1:0]] <= wr_ent;
  end

endmodule
